// File: rtl/stream_fifo.sv
// stream_fifo: first-word fall-through FIFO for the ctrl/data stream bundle,
// reporting occupancy and the number of complete frames held.
module stream_fifo #(
  parameter int DEPTH     = 8,
  parameter int CTRL_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CTRL_BITS-1:0]         s__ctrl,
  input  logic [DATA_BITS-1:0]         s__data,
  input  logic                         s__valid,
  output logic                         s__ready,
  output logic [CTRL_BITS-1:0]         t__ctrl,
  output logic [DATA_BITS-1:0]         t__data,
  output logic                         t__valid,
  input  logic                         t__ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   frames,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = CTRL_BITS + DATA_BITS;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nx;
  logic          push, pop;
  assign push     = s__valid && s__ready;
  assign pop      = t__valid && t__ready;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign t__valid = !empty;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign head     = mem[rd_ptr];
  // Masking with t__valid keeps the unreset storage from ever reaching the outputs.
  assign {t__ctrl, t__data} = t__valid ? head : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      frames   <= '0;
      s__ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nx;
      frames   <= frames + CW'(push && s__ctrl[0]) - CW'(pop && head[DATA_BITS]);
      s__ready <= count_nx != CW'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s__ctrl, s__data};
  end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed and random stimulus; a scoreboard queue is filled on
// accepted beats and emptied by a monitor on every output handshake.
module tb_stream_fifo;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  s__ctrl = 0;
  logic [31:0] s__data = 0;
  logic        s__valid = 0;
  logic        s__ready;
  logic [7:0]  t__ctrl;
  logic [31:0] t__data;
  logic        t__valid;
  logic        t__ready = 0;
  logic [3:0]  count, frames;
  logic        full, empty;
  logic [39:0] q[$];
  int          checks = 0, errors = 0, mc = 0, mf = 0, nout = 0;
  logic [3:0]  c;

  stream_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .s__ctrl(s__ctrl), .s__data(s__data), .s__valid(s__valid), .s__ready(s__ready),
    .t__ctrl(t__ctrl), .t__data(t__data), .t__valid(t__valid), .t__ready(t__ready),
    .count(count), .frames(frames), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference occupancy model plus scoreboard pop on each output handshake.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst_n) begin
      q.delete();
      mc = 0;
      mf = 0;
    end else begin
      chk("count", 64'(count), 64'(mc));
      chk("frames", 64'(frames), 64'(mf));
      chk("t_valid", 64'(t__valid), 64'(mc != 0));
      chk("full", 64'(full), 64'(mc == 8));
      chk("empty", 64'(empty), 64'(mc == 0));
      if (t__valid && t__ready) begin
        if (q.size() == 0) chk("pop_on_empty_sb", 64'(1), 64'(0));
        else begin
          e = q.pop_front();
          chk("head", {24'h0, t__ctrl, t__data}, {24'h0, e});
          mc--;
          mf -= int'(e[32]);
          nout++;
        end
      end
      if (s__valid && s__ready) begin
        mc++;
        mf += int'(s__ctrl[0]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cc, input logic [31:0] d, output logic [3:0] cnt);
    bit done = 0;
    s__valid = 1;
    s__ctrl  = cc;
    s__data  = d;
    cnt = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (s__ready) begin
        q.push_back({cc, d});
        cnt = count;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", 64'(0), 64'(1));
    tick();
  endtask

  task automatic drain;
    bit done = 0;
    s__valid = 0;
    t__ready = 1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (empty) done = 1;
    end
    if (!done) chk("drain_timeout", 64'(0), 64'(1));
    tick();
    t__ready = 0;
  endtask

  initial begin
    #2;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_frames", 64'(frames), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_valid", 64'(t__valid), 64'(0));
    chk("rst_s_ready", 64'(s__ready), 64'(0));
    chk("rst_t_data", 64'(t__data), 64'(0));
    tick();
    rst_n = 1;
    tick();
    chk("s_ready_after_rst", 64'(s__ready), 64'(1));

    // single beat, no bypass
    s__valid = 1; s__ctrl = 8'h01; s__data = 32'hDEADBEEF;
    @(negedge clk);
    chk("empty_in_push_cycle", 64'(empty), 64'(1));
    chk("ready_in_push_cycle", 64'(s__ready), 64'(1));
    q.push_back({8'h01, 32'hDEADBEEF});
    tick();
    s__valid = 0;
    @(negedge clk);
    chk("single_valid", 64'(t__valid), 64'(1));
    chk("single_data", 64'(t__data), 64'hDEADBEEF);
    chk("single_count", 64'(count), 64'(1));
    chk("single_frames", 64'(frames), 64'(1));
    drain();

    // fill to full, pop once
    for (int i = 0; i < 8; i++) send((i == 7) ? 8'h01 : 8'h00, 32'(i), c);
    s__valid = 0;
    @(negedge clk);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_s_ready", 64'(s__ready), 64'(0));
    chk("fill_count", 64'(count), 64'(8));
    chk("fill_frames", 64'(frames), 64'(1));
    tick();
    t__ready = 1;
    @(negedge clk);
    chk("pop_cycle_s_ready", 64'(s__ready), 64'(0));
    tick();
    t__ready = 0;
    @(negedge clk);
    chk("after_pop_s_ready", 64'(s__ready), 64'(1));
    chk("after_pop_count", 64'(count), 64'(7));
    chk("after_pop_frames", 64'(frames), 64'(1));
    drain();

    // continuous streaming through many wraps
    nout = 0;
    t__ready = 1;
    for (int i = 0; i < 100; i++) begin
      send(8'h00, 32'(i), c);
      if (i > 0) chk("stream_count", 64'(c), 64'(1));
    end
    drain();
    chk("stream_nout", 64'(nout), 64'(100));

    // random valid/ready with held upstream beats
    begin
      int n = 0, cyc = 0;
      bit pend = 0;
      while (n < 1000 && cyc < 20000) begin
        if (!pend) begin
          s__valid = 1'($urandom_range(1));
          s__ctrl  = 8'($urandom);
          s__data  = $urandom;
        end
        t__ready = 1'($urandom_range(1));
        @(negedge clk);
        pend = s__valid && !s__ready;
        if (s__valid && s__ready) begin
          q.push_back({s__ctrl, s__data});
          n++;
        end
        tick();
        cyc++;
      end
      chk("random_beats", 64'(n), 64'(1000));
    end
    drain();
    chk("random_sb_empty", 64'(q.size()), 64'(0));

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) send(8'h01, 32'(100 + i), c);
    s__valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", 64'(t__valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_frames", 64'(frames), 64'(0));
    chk("arst_data", 64'(t__data), 64'(0));
    tick();
    rst_n = 1;
    send(8'h00, 32'h12345678, c);
    s__valid = 0;
    @(negedge clk);
    chk("post_rst_head", 64'(t__data), 64'h12345678);
    chk("post_rst_count", 64'(count), 64'(1));
    drain();

    // backpressure hold
    send(8'h00, 32'hA5A5A5A5, c);
    for (int k = 0; k < 10; k++) begin
      s__valid = (k < 3);
      s__ctrl  = 8'h00;
      s__data  = 32'(k + 1);
      @(negedge clk);
      chk("hold_data", 64'(t__data), 64'hA5A5A5A5);
      chk("hold_ctrl", 64'(t__ctrl), 64'(0));
      if (s__valid && s__ready) q.push_back({s__ctrl, s__data});
      tick();
    end
    s__valid = 0;
    @(negedge clk);
    chk("hold_count", 64'(count), 64'(4));
    drain();
    chk("final_sb_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
